// File: rtl/avg_n_controller_pkg.sv
// avg_pkg: shared types and constants for the N-sample moving-average controller.
//   state_t      - controller FSM states
//   OP_*         - ALU micro-op codes driven on op
//   staging_idx  - register index of the staging register S (N+1)
//   acc_idx      - register index of the accumulator A (N+2)
package avg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ERR      = 3'd1,
        STORE    = 3'd2,
        SHIFT    = 3'd3,
        SUM_INIT = 3'd4,
        SUM      = 3'd5
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    // Staging register sits directly above the N-deep window.
    function automatic int staging_idx(input int num_samples);
        return num_samples + 32'sd1;
    endfunction

    // Accumulator sits directly above the staging register.
    function automatic int acc_idx(input int num_samples);
        return num_samples + 32'sd2;
    endfunction

endpackage

// File: rtl/avg_n_controller_if.sv
// avg_n_controller_if: control bundle between the averaging FSM and its datapath.
//   dr, overflow, clr          - datapath/source -> controller
//   cnt_up, modwait, op,
//   src1, src2, dest, err,
//   window_full, done          - controller -> datapath/consumer
// master modport is the controller side, slave the datapath/source side.
interface avg_n_controller_if #(
    parameter int REG_W = 4
);

    logic             dr;
    logic             overflow;
    logic             clr;
    logic             cnt_up;
    logic             modwait;
    logic [1:0]       op;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dest;
    logic             err;
    logic             window_full;
    logic             done;

    modport master (
        input  dr, overflow, clr,
        output cnt_up, modwait, op, src1, src2, dest, err, window_full, done
    );

    modport slave (
        output dr, overflow, clr,
        input  cnt_up, modwait, op, src1, src2, dest, err, window_full, done
    );

endinterface

// File: rtl/avg_n_controller_sample_fill_counter.sv
// sample_fill_counter: saturating 0..NUM_SAMPLES count of samples stored.
//   clk, n_reset - clock, async active-low reset
//   clr          - synchronous clear (wins over inc)
//   inc          - count one stored sample
//   full         - registered, high while count == NUM_SAMPLES
module sample_fill_counter #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clr,
    input  logic inc,
    output logic full
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] FILL_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] FILL_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] fill_r;
    logic [CNT_W-1:0] fill_next_s;
    logic             full_r;

    // Next fill value: clear, saturating increment, or hold.
    always_comb begin
        fill_next_s = fill_r;
        if (clr) begin
            fill_next_s = FILL_ZERO;
        end else if (inc && (fill_r != FILL_MAX)) begin
            fill_next_s = fill_r + FILL_ONE;
        end else begin
            fill_next_s = fill_r;
        end
    end

    // Fill count and its full flag, registered together so full tracks the count.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            fill_r <= FILL_ZERO;
            full_r <= 1'b0;
        end else begin
            fill_r <= fill_next_s;
            full_r <= (fill_next_s == FILL_MAX);
        end
    end

    assign full = full_r;

endmodule

// File: rtl/avg_n_controller.sv
// avg_n_controller: control FSM for an N-sample moving-average datapath.
// On each sample it loads the staging register, shifts the window down by one
// (reg1 oldest) and sums reg1..regN into reg0 through the accumulator.
//   clk, n_reset - clock, async active-low reset
//   bus (master) - dr/overflow/clr in; cnt_up, modwait, op, src1, src2, dest,
//                  err, window_full, done out (all registered)
// The consumer divides reg0 by N with a fixed right shift of log2(N).
module avg_n_controller
    import avg_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int REG_W       = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    avg_n_controller_if.master       bus
);

    if (!((NUM_SAMPLES == 2) || (NUM_SAMPLES == 4) || (NUM_SAMPLES == 8))) begin : g_bad_depth
        $error("avg_n_controller: NUM_SAMPLES must be 2, 4 or 8");
    end
    if ((NUM_SAMPLES + 3) > (2 ** REG_W)) begin : g_bad_reg_w
        $error("avg_n_controller: REG_W too narrow for NUM_SAMPLES+3 registers");
    end

    localparam int IDX_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] IDX_TWO  = IDX_W'(2'd2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMPLES);

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [REG_W-1:0] REG_ONE  = REG_W'(1'b1);
    localparam logic [REG_W-1:0] REG_S    = REG_W'(staging_idx(NUM_SAMPLES));
    localparam logic [REG_W-1:0] REG_A    = REG_W'(acc_idx(NUM_SAMPLES));

    state_t           state_r, state_next_s;
    logic [IDX_W-1:0] idx_r, idx_next_s;

    logic             fill_inc_s;
    logic             full_s;
    logic             done_next_s;

    logic             cnt_up_s, modwait_s, err_s;
    logic [1:0]       op_s;
    logic [REG_W-1:0] src1_s, src2_s, dest_s;

    logic             cnt_up_r, modwait_r, err_r, done_r;
    logic [1:0]       op_r;
    logic [REG_W-1:0] src1_r, src2_r, dest_r;

    // A sample only counts once STORE completes with dr still high.
    assign fill_inc_s = (state_r == STORE) && bus.dr && !bus.clr;

    sample_fill_counter #(
        .NUM_SAMPLES (NUM_SAMPLES)
    ) u_fill (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (bus.clr),
        .inc     (fill_inc_s),
        .full    (full_s)
    );

    // Done only when the last ADD completes cleanly over a full window.
    assign done_next_s = !bus.clr && (state_r == SUM) && (idx_r == IDX_LAST)
                         && !bus.overflow && full_s;

    // Next-state and window index logic; clr overrides everything.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        if (bus.clr) begin
            state_next_s = IDLE;
            idx_next_s   = IDX_ZERO;
        end else begin
            case (state_r)
                IDLE, ERR: begin
                    if (bus.dr) begin
                        state_next_s = STORE;
                    end else begin
                        state_next_s = state_r;
                    end
                    idx_next_s = IDX_ZERO;
                end
                STORE: begin
                    // dr gone before the shift can start: the sample is lost.
                    if (bus.dr) begin
                        state_next_s = SHIFT;
                        idx_next_s   = IDX_ONE;
                    end else begin
                        state_next_s = ERR;
                        idx_next_s   = IDX_ZERO;
                    end
                end
                SHIFT: begin
                    if (idx_r < IDX_LAST) begin
                        state_next_s = SHIFT;
                        idx_next_s   = idx_r + IDX_ONE;
                    end else begin
                        state_next_s = SUM_INIT;
                        idx_next_s   = IDX_ZERO;
                    end
                end
                SUM_INIT: begin
                    state_next_s = SUM;
                    idx_next_s   = IDX_TWO;
                end
                SUM: begin
                    if (bus.overflow) begin
                        state_next_s = ERR;
                        idx_next_s   = IDX_ZERO;
                    end else if (idx_r < IDX_LAST) begin
                        state_next_s = SUM;
                        idx_next_s   = idx_r + IDX_ONE;
                    end else begin
                        state_next_s = IDLE;
                        idx_next_s   = IDX_ZERO;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    idx_next_s   = IDX_ZERO;
                end
            endcase
        end
    end

    // Moore decode of the upcoming (state, idx) so the output registers line up with the state register.
    always_comb begin
        cnt_up_s  = 1'b0;
        modwait_s = 1'b0;
        err_s     = 1'b0;
        op_s      = OP_NOP;
        src1_s    = REG_ZERO;
        src2_s    = REG_ZERO;
        dest_s    = REG_ZERO;
        case (state_next_s)
            IDLE: begin
                modwait_s = 1'b0;
            end
            ERR: begin
                err_s = 1'b1;
            end
            STORE: begin
                modwait_s = 1'b1;
                cnt_up_s  = 1'b1;
                op_s      = OP_LOAD;
                dest_s    = REG_S;
            end
            SHIFT: begin
                // At idx=N the source idx+1 is the staging register.
                modwait_s = 1'b1;
                op_s      = OP_COPY;
                src1_s    = REG_W'(idx_next_s) + REG_ONE;
                dest_s    = REG_W'(idx_next_s);
            end
            SUM_INIT: begin
                modwait_s = 1'b1;
                op_s      = OP_COPY;
                src1_s    = REG_ONE;
                dest_s    = REG_A;
            end
            SUM: begin
                // The final ADD writes straight to the result register.
                modwait_s = 1'b1;
                op_s      = OP_ADD;
                src1_s    = REG_A;
                src2_s    = REG_W'(idx_next_s);
                if (idx_next_s == IDX_LAST) begin
                    dest_s = REG_ZERO;
                end else begin
                    dest_s = REG_A;
                end
            end
            default: begin
                modwait_s = 1'b0;
            end
        endcase
    end

    // State, index and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r   <= IDLE;
            idx_r     <= IDX_ZERO;
            cnt_up_r  <= 1'b0;
            modwait_r <= 1'b0;
            err_r     <= 1'b0;
            done_r    <= 1'b0;
            op_r      <= OP_NOP;
            src1_r    <= REG_ZERO;
            src2_r    <= REG_ZERO;
            dest_r    <= REG_ZERO;
        end else begin
            state_r   <= state_next_s;
            idx_r     <= idx_next_s;
            cnt_up_r  <= cnt_up_s;
            modwait_r <= modwait_s;
            err_r     <= err_s;
            done_r    <= done_next_s;
            op_r      <= op_s;
            src1_r    <= src1_s;
            src2_r    <= src2_s;
            dest_r    <= dest_s;
        end
    end

    assign bus.cnt_up      = cnt_up_r;
    assign bus.modwait     = modwait_r;
    assign bus.op          = op_r;
    assign bus.src1        = src1_r;
    assign bus.src2        = src2_r;
    assign bus.dest        = dest_r;
    assign bus.err         = err_r;
    assign bus.window_full = full_s;
    assign bus.done        = done_r;

endmodule

// File: tb/tb_avg_n_controller.sv
// Bench for avg_n_controller: a table of per-cycle vectors for N=4, directed
// sequences for clr, STORE error, overflow and reset, and an N=8 latency run.
module tb_avg_n_controller;
    import avg_pkg::*;

    typedef struct packed {
        logic       cnt_up;
        logic       modwait;
        logic [1:0] op;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [3:0] dest;
        logic       err;
        logic       window_full;
        logic       done;
    } outs_t;

    typedef struct {
        logic  dr;
        logic  ovf;
        logic  clr;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    avg_n_controller_if #(.REG_W(4)) bus4 ();
    avg_n_controller_if #(.REG_W(4)) bus8 ();

    avg_n_controller #(.NUM_SAMPLES(4), .REG_W(4)) dut4 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus4.master)
    );

    avg_n_controller #(.NUM_SAMPLES(8), .REG_W(4)) dut8 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus8.master)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    function automatic outs_t mk(input logic cu, input logic mw, input logic [1:0] op,
                                 input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                                 input logic e, input logic wf, input logic dn);
        outs_t o;
        o = '{cu, mw, op, s1, s2, d, e, wf, dn};
        return o;
    endfunction

    function automatic outs_t idle_out(input logic wf, input logic dn);
        return mk(1'b0, 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 1'b0, wf, dn);
    endfunction

    function outs_t read4();
        return '{bus4.cnt_up, bus4.modwait, bus4.op, bus4.src1, bus4.src2, bus4.dest,
                 bus4.err, bus4.window_full, bus4.done};
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = read4();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cu=%b mw=%b op=%0d s1=%0d s2=%0d d=%0d err=%b wf=%b done=%b, expected cu=%b mw=%b op=%0d s1=%0d s2=%0d d=%0d err=%b wf=%b done=%b",
                     name, act.cnt_up, act.modwait, act.op, act.src1, act.src2, act.dest,
                     act.err, act.window_full, act.done,
                     exp.cnt_up, exp.modwait, exp.op, exp.src1, exp.src2, exp.dest,
                     exp.err, exp.window_full, exp.done);
        end
    endtask

    task automatic step(input logic dr, input logic ovf, input logic clr);
        bus4.dr       = dr;
        bus4.overflow = ovf;
        bus4.clr      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic dr, input outs_t e);
        vecs.push_back('{dr: dr, ovf: 1'b0, clr: 1'b0, exp: e});
    endtask

    // One full N=4 sample, dr held for two cycles; outputs after each edge.
    task automatic add_sample(input logic wf_before, input logic wf_after, input logic dn);
        push(1'b1, mk(1'b1, 1'b1, OP_LOAD, 4'd0, 4'd0, 4'd5, 1'b0, wf_before, 1'b0));
        push(1'b1, mk(1'b0, 1'b1, OP_COPY, 4'd2, 4'd0, 4'd1, 1'b0, wf_after, 1'b0));
        push(1'b0, mk(1'b0, 1'b1, OP_COPY, 4'd3, 4'd0, 4'd2, 1'b0, wf_after, 1'b0));
        push(1'b0, mk(1'b0, 1'b1, OP_COPY, 4'd4, 4'd0, 4'd3, 1'b0, wf_after, 1'b0));
        push(1'b0, mk(1'b0, 1'b1, OP_COPY, 4'd5, 4'd0, 4'd4, 1'b0, wf_after, 1'b0));
        push(1'b0, mk(1'b0, 1'b1, OP_COPY, 4'd1, 4'd0, 4'd6, 1'b0, wf_after, 1'b0));
        push(1'b0, mk(1'b0, 1'b1, OP_ADD,  4'd6, 4'd2, 4'd6, 1'b0, wf_after, 1'b0));
        push(1'b0, mk(1'b0, 1'b1, OP_ADD,  4'd6, 4'd3, 4'd6, 1'b0, wf_after, 1'b0));
        push(1'b0, mk(1'b0, 1'b1, OP_ADD,  4'd6, 4'd4, 4'd0, 1'b0, wf_after, 1'b0));
        push(1'b0, idle_out(wf_after, dn));
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            step(vecs[i].dr, vecs[i].ovf, vecs[i].clr);
            check($sformatf("%s[%0d]", tag, i), vecs[i].exp);
        end
        vecs.delete();
    endtask

    initial begin
        int         mw_cycles;
        logic [1:0] last_op;
        logic [3:0] last_s1, last_s2, last_d;

        n_reset       = 1'b0;
        bus4.dr       = 1'b0;
        bus4.overflow = 1'b0;
        bus4.clr      = 1'b0;
        bus8.dr       = 1'b0;
        bus8.overflow = 1'b0;
        bus8.clr      = 1'b0;

        // Table: four samples filling the window, then one idle cycle.
        add_sample(1'b0, 1'b0, 1'b0);
        add_sample(1'b0, 1'b0, 1'b0);
        add_sample(1'b0, 1'b0, 1'b0);
        add_sample(1'b0, 1'b1, 1'b1);
        push(1'b0, idle_out(1'b1, 1'b0));

        #12;
        check("reset_held", idle_out(1'b0, 1'b0));
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("reset_idle", idle_out(1'b0, 1'b0));

        run_vecs("fill");

        // clr during SHIFT idx=2 discards the window.
        step(1'b1, 1'b0, 1'b0);
        check("clr_store", mk(1'b1, 1'b1, OP_LOAD, 4'd0, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0));
        step(1'b1, 1'b0, 1'b0);
        check("clr_shift1", mk(1'b0, 1'b1, OP_COPY, 4'd2, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1'b0);
        check("clr_shift2", mk(1'b0, 1'b1, OP_COPY, 4'd3, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1'b1);
        check("clr_idle", idle_out(1'b0, 1'b0));
        step(1'b1, 1'b0, 1'b1);
        check("clr_over_dr", idle_out(1'b0, 1'b0));

        // Three samples, then a dropped STORE that must not count.
        add_sample(1'b0, 1'b0, 1'b0);
        add_sample(1'b0, 1'b0, 1'b0);
        add_sample(1'b0, 1'b0, 1'b0);
        run_vecs("refill");
        step(1'b1, 1'b0, 1'b0);
        check("err_store", mk(1'b1, 1'b1, OP_LOAD, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0);
        check("err_enter", mk(1'b0, 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0);
        check("err_hold", mk(1'b0, 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        add_sample(1'b0, 1'b1, 1'b1);
        run_vecs("recover");

        // Overflow on ADD 6+3->6 aborts into ERR without done.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0);
        end
        check("ovf_sum3", mk(1'b0, 1'b1, OP_ADD, 4'd6, 4'd3, 4'd6, 1'b0, 1'b1, 1'b0));
        step(1'b0, 1'b1, 1'b0);
        check("ovf_err", mk(1'b0, 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1'b0);
        check("ovf_no_add", mk(1'b0, 1'b0, OP_NOP, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0));

        // Asynchronous reset in the middle of SUM.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0);
        end
        check("rst_sum2", mk(1'b0, 1'b1, OP_ADD, 4'd6, 4'd2, 4'd6, 1'b0, 1'b1, 1'b0));
        #2;
        n_reset = 1'b0;
        #1;
        check("rst_async", idle_out(1'b0, 1'b0));
        #3;
        n_reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("rst_release", idle_out(1'b0, 1'b0));

        // N=8: one sample, count busy cycles and capture the last micro-op.
        mw_cycles = 0;
        last_op   = OP_NOP;
        last_s1   = 4'd0;
        last_s2   = 4'd0;
        last_d    = 4'd0;
        bus8.dr   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                bus8.dr = 1'b0;
            end
            if (bus8.modwait) begin
                mw_cycles++;
                last_op = bus8.op;
                last_s1 = bus8.src1;
                last_s2 = bus8.src2;
                last_d  = bus8.dest;
            end
        end
        n_checks++;
        if (mw_cycles != 17) begin
            n_fail++;
            $display("FAIL n8_busy: got %0d modwait cycles, expected 17", mw_cycles);
        end
        n_checks++;
        if ({last_op, last_s1, last_s2, last_d} !== {OP_ADD, 4'd10, 4'd8, 4'd0}) begin
            n_fail++;
            $display("FAIL n8_last_op: got op=%0d s1=%0d s2=%0d d=%0d, expected op=3 s1=10 s2=8 d=0",
                     last_op, last_s1, last_s2, last_d);
        end
        n_checks++;
        if ({bus8.modwait, bus8.done, bus8.window_full} !== 3'b000) begin
            n_fail++;
            $display("FAIL n8_idle: got mw/done/wf=%b, expected 000",
                     {bus8.modwait, bus8.done, bus8.window_full});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
